bmp_udp_streamer: RTL
=====================

Name: bmp_udp_streamer

Overview:
Parametrised successor to the single-buffer BMP-over-UDP sender. It scans SD sectors for a BMP whose width matches bmp_width, then streams the whole file as UDP payloads. Two ping-pong banks let SD reads fill one bank while the other is transmitted. Adds configurable packet size, search base, stride, a search limit with error exit, and a packet counter. It sits between the SD sector reader and the UDP/IP transmit stack.

Parameters:
PKT_BYTES, 1024, payload bytes per full packet; must be a multiple of 512 and ≤ 1472
SEARCH_BASE, 18688, first sector searched; forced to a multiple of SEARCH_STRIDE
SEARCH_STRIDE, 8, sector step between search probes
SEARCH_MAX, 4096, number of probes before search gives up

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
find  in  1  level; start search when in IDLE
sd_init_done  in  1  SD ready; low forces IDLE
bmp_width  in  16  width to match (header bytes 18..19)
ready  out  1  high in IDLE
state_code  out  4  0 SD init, 1 idle, 2 find, 3 read, 4 tx/drain, 5 not found
sd_sec_read  out  1  sector read request, held until sd_sec_read_end
sd_sec_read_addr  out  32  sector address
sd_sec_read_data  in  8  sector byte
sd_sec_read_data_valid  in  1  byte strobe
sd_sec_read_end  in  1  one-cycle end-of-sector pulse
app_tx_data_request  in  1  stack requests payload
app_tx_data_valid  out  1  payload byte valid
app_tx_data  out  8  payload byte
udp_data_length  out  16  length of the pending packet
udp_tx_ready  out  1  a full bank is awaiting transmission
pkt_cnt  out  16  packets sent this file; cleared on find

Behaviour:
- Reset values: all outputs 0, except sd_sec_read_addr = SEARCH_BASE and state_code = 0. Banks are marked empty.
- Main FSM states: IDLE, FIND, STREAM, DRAIN, NOTFOUND.
- sd_init_done = 0 in any state: go to IDLE, drop sd_sec_read, empty both banks, state_code = 0.
- IDLE:
  - find = 1 -> FIND.
  - Probe counter = 0, pkt_cnt = 0.
  - Address aligned down to a multiple of SEARCH_STRIDE.
- FIND:
  - Read one sector. Byte index counter is 10 bits.
  - Capture bytes 0..1 (must be "BM"), 2..5 (file_len, little-endian) and 18..19 (width).
  - Match is evaluated at sd_sec_read_end.
  - On a match: go to STREAM at the same address, and the sector is re-read.
  - On a miss: address += SEARCH_STRIDE and the probe counter increments.
  - Probe counter reaching SEARCH_MAX -> NOTFOUND.
- NOTFOUND: state_code = 5; held until find is low for 1 cycle, then IDLE.
- STREAM, fill side:
  - Writes the fill bank at wr_ptr, byte_cnt++.
  - Bytes with byte_cnt ≥ file_len are discarded but the sector still completes.
  - At sector end: address += 1.
  - If wr_ptr == PKT_BYTES, or byte_cnt ≥ file_len: mark the bank full with length wr_ptr, then swap banks.
  - The next sector read is issued only when the fill bank is empty. Otherwise sd_sec_read stays low (stall).
- Transmit side (independent sub-FSM: TX_IDLE, TX_OFFER, TX_SEND):
  - TX_OFFER: udp_tx_ready = 1 and udp_data_length = bank length.
  - app_tx_data_request high in TX_OFFER -> TX_SEND. The first byte appears 1 cycle later (synchronous RAM read).
  - valid stays high for exactly length consecutive cycles; request is ignored while sending.
  - After the last byte: valid = 0, bank marked empty, pkt_cnt++, back to TX_IDLE.
  - A bank must never be marked full and empty in the same cycle. If the fill side completes a bank while TX frees the other, both updates take effect.
- DRAIN: entered when byte_cnt ≥ file_len. Waits until both banks are empty, then goes to IDLE; pkt_cnt is held.
- file_len = 0 or < 54: treated as a miss.
- Reset mid-transfer clears everything asynchronously; valid drops immediately.

Optional Feature:
BMP_UDP_SEQ_HDR_EN.
- Defined: each packet is prefixed with 4 bytes, {pkt_cnt[15:0] big-endian, 16'hB0B0}. udp_data_length = length + 4, and the header bytes precede the payload in TX_SEND.
- Undefined: no prefix, and udp_data_length = payload length.

Test Plan:
- BMP "BM", width 640 at sector 18688, file_len 1500, bmp_width 640, find -> 2 packets of 1024 and 476 bytes, bytes equal file bytes 0..1499, pkt_cnt = 2, then ready = 1.
- Width 320 at 18688, width 640 at 18696, bmp_width 640 -> probe at 18688 misses, stream starts at 18696, first sector read twice.
- No match, SEARCH_MAX = 4 -> addresses 18688, 18696, 18704, 18712 probed, then state_code = 5.
- app_tx_data_request withheld for 3000 cycles during a 4096-byte file -> sd_sec_read stays low after both banks fill; no byte lost or duplicated after request.
- rst_n low mid-TX_SEND at byte 300 -> valid = 0 immediately; after release state_code = 0/1 and the banks are empty.
- With BMP_UDP_SEQ_HDR_EN, file_len 1500 -> lengths 1028 and 480, headers 00 00 B0 B0 and 00 01 B0 B0.

Source files
------------

// File: rtl/bmp_udp_streamer.sv
// bmp_udp_streamer
// Scans SD sectors for a BMP whose header width matches bmp_width, then
// streams the whole file as UDP payloads through two ping-pong banks. SD
// reads fill one bank while the other one is transmitted.
//
// Optional build macro: BMP_UDP_SEQ_HDR_EN. When defined, every packet
// gets a 4-byte prefix {pkt_cnt big-endian, 16'hB0B0}.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   find, sd_init_done, bmp_width search control / match width
//   ready, state_code             status (0 init,1 idle,2 find,3 read,4 drain,5 not found)
//   sd_sec_read*                  SD sector reader handshake and byte stream
//   app_tx_data_request/valid/data, udp_data_length, udp_tx_ready
//                                 UDP payload interface
//   pkt_cnt                       packets sent for the current file
module bmp_udp_streamer #(
  parameter int PKT_BYTES     = 1024,
  parameter int SEARCH_BASE   = 18688,
  parameter int SEARCH_STRIDE = 8,
  parameter int SEARCH_MAX    = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        find,
  input  logic        sd_init_done,
  input  logic [15:0] bmp_width,
  output logic        ready,
  output logic [3:0]  state_code,
  output logic        sd_sec_read,
  output logic [31:0] sd_sec_read_addr,
  input  logic [7:0]  sd_sec_read_data,
  input  logic        sd_sec_read_data_valid,
  input  logic        sd_sec_read_end,
  input  logic        app_tx_data_request,
  output logic        app_tx_data_valid,
  output logic [7:0]  app_tx_data,
  output logic [15:0] udp_data_length,
  output logic        udp_tx_ready,
  output logic [15:0] pkt_cnt
);
  localparam int          AW      = $clog2(PKT_BYTES);
  localparam logic [31:0] STRIDE  = 32'(SEARCH_STRIDE);
  localparam logic [31:0] BASE_AL = 32'((SEARCH_BASE / SEARCH_STRIDE) * SEARCH_STRIDE);
  localparam logic [10:0] PKT_LEN = 11'(PKT_BYTES);
`ifdef BMP_UDP_SEQ_HDR_EN
  localparam logic [10:0] HDR_LEN = 11'd4;
`else
  localparam logic [10:0] HDR_LEN = 11'd0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0, S_FIND = 3'd1, S_STREAM = 3'd2,
                         S_DRAIN = 3'd3, S_NOTFOUND = 3'd4;
  localparam logic [1:0] TX_IDLE = 2'd0, TX_OFFER = 2'd1, TX_SEND = 2'd2;

  logic [2:0]  state_q, state_d;
  logic [1:0]  tx_state_q, tx_state_d;
  logic        rd_q, rd_d;
  logic [31:0] addr_q, addr_d, probe_q, probe_d;
  logic [9:0]  idx_q, idx_d;
  logic [15:0] sig_q, sig_d, width_q, width_d;
  logic [31:0] flen_q, flen_d, bcnt_q, bcnt_d;
  logic [10:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        fill_sel_q, fill_sel_d, tx_sel_q, tx_sel_d;
  logic [1:0]  full_q, full_d, full_set, full_clr;
  logic [10:0] len_q [2];
  logic [10:0] len_d [2];
  logic        vld_q, vld_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [3:0]  state_code_q, state_code_d;
  logic        ready_q, ready_d;

  logic        we, issue;
  logic [10:0] issue_idx, pay_off, tx_total;
  logic [AW:0] waddr, raddr_d;
  logic [7:0]  mem [2*PKT_BYTES];
  logic [7:0]  rdata_q;

  assign tx_total = len_q[tx_sel_q] + HDR_LEN;

  always_comb begin
    state_d = state_q;   tx_state_d = tx_state_q; rd_d = rd_q;
    addr_d = addr_q;     probe_d = probe_q;       idx_d = idx_q;
    sig_d = sig_q;       width_d = width_q;       flen_d = flen_q;
    bcnt_d = bcnt_q;     wptr_d = wptr_q;         rptr_d = rptr_q;
    fill_sel_d = fill_sel_q; tx_sel_d = tx_sel_q;
    len_d = len_q;       pkt_cnt_d = pkt_cnt_q;
    full_set = 2'b00;    full_clr = 2'b00;
    we = 1'b0;           issue = 1'b0;            issue_idx = 11'd0;

    // Transmit side: offer a full bank, then read it out one byte per cycle.
    case (tx_state_q)
      TX_IDLE:  if (full_q[tx_sel_q]) tx_state_d = TX_OFFER;
      TX_OFFER: if (app_tx_data_request) begin
        tx_state_d = TX_SEND;
        issue      = 1'b1;
        rptr_d     = 11'd1;
      end
      TX_SEND: begin
        if (rptr_q < tx_total) begin
          issue     = 1'b1;
          issue_idx = rptr_q;
          rptr_d    = rptr_q + 11'd1;
        end else begin
          full_clr[tx_sel_q] = 1'b1;
          pkt_cnt_d  = pkt_cnt_q + 16'd1;
          tx_sel_d   = ~tx_sel_q;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Search / fill side.
    case (state_q)
      S_IDLE: begin
        rd_d    = 1'b0;
        probe_d = 32'd0;
        addr_d  = addr_q - (addr_q % STRIDE);
        if (find) begin
          state_d   = S_FIND;
          pkt_cnt_d = 16'd0;
        end
      end
      S_FIND: begin
        if (!rd_q) begin
          rd_d = 1'b1;  idx_d = 10'd0;
          sig_d = 16'd0; width_d = 16'd0; flen_d = 32'd0;
        end else begin
          if (sd_sec_read_data_valid) begin
            idx_d = idx_q + 10'd1;
            case (idx_q)
              10'd0:  sig_d[15:8]    = sd_sec_read_data;
              10'd1:  sig_d[7:0]     = sd_sec_read_data;
              10'd2:  flen_d[7:0]    = sd_sec_read_data;
              10'd3:  flen_d[15:8]   = sd_sec_read_data;
              10'd4:  flen_d[23:16]  = sd_sec_read_data;
              10'd5:  flen_d[31:24]  = sd_sec_read_data;
              10'd18: width_d[7:0]   = sd_sec_read_data;
              10'd19: width_d[15:8]  = sd_sec_read_data;
              default: ;
            endcase
          end
          if (sd_sec_read_end) begin
            rd_d = 1'b0;
            // Lengths below a bare BMP header cannot be a real image.
            if (sig_q == 16'h424D && width_q == bmp_width && flen_q >= 32'd54) begin
              state_d = S_STREAM;
              bcnt_d  = 32'd0;
              wptr_d  = 11'd0;
            end else begin
              addr_d  = addr_q + STRIDE;
              probe_d = probe_q + 32'd1;
              if (probe_q + 32'd1 == 32'(SEARCH_MAX)) state_d = S_NOTFOUND;
            end
          end
        end
      end
      S_STREAM: begin
        if (!rd_q) begin
          // Stall the SD side until the fill bank has been transmitted.
          if (!full_q[fill_sel_q]) rd_d = 1'b1;
        end else begin
          if (sd_sec_read_data_valid && bcnt_q < flen_q) begin
            we     = 1'b1;
            wptr_d = wptr_q + 11'd1;
            bcnt_d = bcnt_q + 32'd1;
          end
          if (sd_sec_read_end) begin
            rd_d   = 1'b0;
            addr_d = addr_q + 32'd1;
            if (wptr_d == PKT_LEN || bcnt_d >= flen_q) begin
              full_set[fill_sel_q] = 1'b1;
              len_d[fill_sel_q]    = wptr_d;
              fill_sel_d           = ~fill_sel_q;
              wptr_d               = 11'd0;
            end
            if (bcnt_d >= flen_q) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        rd_d = 1'b0;
        if (full_q == 2'b00 && tx_state_q == TX_IDLE) state_d = S_IDLE;
      end
      S_NOTFOUND: if (!find) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    full_d = (full_q & ~full_clr) | full_set;
    vld_d  = issue;

    if (!sd_init_done) begin
      state_d = S_IDLE;   tx_state_d = TX_IDLE; rd_d = 1'b0;
      full_d = 2'b00;     vld_d = 1'b0;         wptr_d = 11'd0;
      fill_sel_d = 1'b0;  tx_sel_d = 1'b0;
    end

    case (state_d)
      S_IDLE:     state_code_d = 4'd1;
      S_FIND:     state_code_d = 4'd2;
      S_STREAM:   state_code_d = 4'd3;
      S_DRAIN:    state_code_d = 4'd4;
      default:    state_code_d = 4'd5;
    endcase
    if (!sd_init_done) state_code_d = 4'd0;
    ready_d = sd_init_done && (state_d == S_IDLE);

    waddr   = {fill_sel_q, wptr_q[AW-1:0]};
    pay_off = issue_idx - HDR_LEN;
    raddr_d = {tx_sel_q, pay_off[AW-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;   tx_state_q <= TX_IDLE; rd_q <= 1'b0;
      addr_q <= BASE_AL;   probe_q <= 32'd0;      idx_q <= 10'd0;
      sig_q <= 16'd0;      width_q <= 16'd0;      flen_q <= 32'd0;
      bcnt_q <= 32'd0;     wptr_q <= 11'd0;       rptr_q <= 11'd0;
      fill_sel_q <= 1'b0;  tx_sel_q <= 1'b0;      full_q <= 2'b00;
      len_q[0] <= 11'd0;   len_q[1] <= 11'd0;     vld_q <= 1'b0;
      pkt_cnt_q <= 16'd0;  state_code_q <= 4'd0;  ready_q <= 1'b0;
    end else begin
      state_q <= state_d;  tx_state_q <= tx_state_d; rd_q <= rd_d;
      addr_q <= addr_d;    probe_q <= probe_d;    idx_q <= idx_d;
      sig_q <= sig_d;      width_q <= width_d;    flen_q <= flen_d;
      bcnt_q <= bcnt_d;    wptr_q <= wptr_d;      rptr_q <= rptr_d;
      fill_sel_q <= fill_sel_d; tx_sel_q <= tx_sel_d; full_q <= full_d;
      len_q <= len_d;      vld_q <= vld_d;
      pkt_cnt_q <= pkt_cnt_d; state_code_q <= state_code_d; ready_q <= ready_d;
    end
  end

  // Bank RAM: synchronous read, so a byte is valid one cycle after issue.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= sd_sec_read_data;
    rdata_q <= mem[raddr_d];
  end

`ifdef BMP_UDP_SEQ_HDR_EN
  logic       hdr_flag_q, hdr_flag_d;
  logic [7:0] hdr_byte_q, hdr_byte_d;
  always_comb begin
    hdr_flag_d = issue && (issue_idx < HDR_LEN);
    case (issue_idx[1:0])
      2'd0:    hdr_byte_d = pkt_cnt_q[15:8];
      2'd1:    hdr_byte_d = pkt_cnt_q[7:0];
      default: hdr_byte_d = 8'hB0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_flag_q <= 1'b0;
      hdr_byte_q <= 8'd0;
    end else begin
      hdr_flag_q <= hdr_flag_d;
      hdr_byte_q <= hdr_byte_d;
    end
  end
  assign app_tx_data = hdr_flag_q ? hdr_byte_q : rdata_q;
`else
  assign app_tx_data = rdata_q;
`endif

  assign ready             = ready_q;
  assign state_code        = state_code_q;
  assign sd_sec_read       = rd_q;
  assign sd_sec_read_addr  = addr_q;
  assign app_tx_data_valid = vld_q;
  assign udp_tx_ready      = (tx_state_q == TX_OFFER);
  assign udp_data_length   = (tx_state_q == TX_OFFER) ? {5'd0, tx_total} : 16'd0;
  assign pkt_cnt           = pkt_cnt_q;
endmodule
